seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl_pkg.sv | 23 ++
 rtl/seg7_scan_ctrl_if.sv | 21 ++
 rtl/seg7_scan_ctrl_seg7.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
// scan FSM state encoding, digit count, default slot timing and a
// digit-index to one-hot helper.
package seg7_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   localparam int DIGITS       = 4;
   localparam int IDX_W        = $clog2(DIGITS);
   localparam int CLK_DIV_DEF  = 1000;
   localparam int DEAD_CYC_DEF = 4;

   // One-hot digit enable for a digit index.
   function automatic logic [DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
      return {{(DIGITS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
// Load handshake and display drive of the scan controller.
//   en        : scan enable (low forces display off)
//   load      : request to accept data_in (transfer when load && ready)
//   ready     : a new value can be accepted
//   data_in   : four nibbles, nibble k drives digit k
//   digit_sel : one-hot active-high digit enable
//   segments  : segment pattern for the enabled digit
interface seg7_scan_ctrl_if;
   import seg7_scan_ctrl_pkg::*;

   logic              en;
   logic              load;
   logic              ready;
   logic [15:0]       data_in;
   logic [DIGITS-1:0] digit_sel;
   logic [6:0]        segments;

   modport master (output en, load, data_in, input ready, digit_sel, segments);
   modport slave  (input en, load, data_in, output ready, digit_sel, segments);
endinterface

// File: rtl/seg7_scan_ctrl_seg7.sv
// seg7
// Nibble-to-segment decoder used by the board's display. The pattern set
// is the board's legacy encoding (e.g. 1 -> 7'b1010000, 5 -> 7'b1011110),
// not the textbook gfedcba glyph set.
//   nibble   : value to display
//   segments : segment pattern
module seg7 (
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   // Combinational lookup of the legacy pattern table.
   always_comb begin
      segments = 7'b0000000;
      case (nibble)
         4'h0:    segments = 7'b0111111;
         4'h1:    segments = 7'b1010000;
         4'h2:    segments = 7'b1011011;
         4'h3:    segments = 7'b1001111;
         4'h4:    segments = 7'b1100110;
         4'h5:    segments = 7'b1011110;
         4'h6:    segments = 7'b1111101;
         4'h7:    segments = 7'b0000111;
         4'h8:    segments = 7'b1111111;
         4'h9:    segments = 7'b1101111;
         4'hA:    segments = 7'b1110111;
         4'hB:    segments = 7'b1111100;
         4'hC:    segments = 7'b0111001;
         4'hD:    segments = 7'b0011110;
         4'hE:    segments = 7'b1111001;
         4'hF:    segments = 7'b1110001;
         default: segments = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed 4-digit 7-segment scan controller. Each digit owns a
// slot of CLK_DIV cycles; the first DEAD_CYC cycles of a slot are blanked
// to avoid ghosting. New values go through a single-entry shadow register
// and are committed only at a frame boundary, so a frame never mixes two
// loads.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake/display interface (slave side)
import seg7_scan_ctrl_pkg::*;

module seg7_scan_ctrl #(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int DEAD_CYC = DEAD_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   seg7_scan_ctrl_if.slave  bus
);

   localparam int            CW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST_C = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   state_t             state_r, state_s;
   logic [CW-1:0]      cnt_r, cnt_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic [15:0]        shadow_r, shadow_s;
   logic [15:0]        disp_r, disp_s;
   logic               pending_r, pending_s;
   logic               valid_r, valid_s;
   logic               commit_s, capture_s, wrap_s;
   logic [3:0]         nib_s;
   logic [6:0]         dec_s;
   logic [DIGITS-1:0]  digit_sel_r, digit_sel_s;
   logic [6:0]         segments_r, segments_s;

   seg7 u_seg7 (
      .nibble   (nib_s),
      .segments (dec_s)
   );

   // Next-state, commit/capture and next-output computation.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      idx_s     = idx_r;
      wrap_s    = 1'b0;
      commit_s  = 1'b0;
      capture_s = bus.load && !pending_r;

      case (state_r)
         ST_OFF: begin
            cnt_s    = '0;
            idx_s    = '0;
            // While dark there is no frame to protect: commit straight away.
            commit_s = pending_r;
            if (bus.en && valid_r) begin
               state_s = ST_BLANK;
            end else begin
               state_s = ST_OFF;
            end
         end
         ST_BLANK, ST_ON: begin
            if (!bus.en) begin
               state_s = ST_OFF;
               cnt_s   = '0;
               idx_s   = '0;
            end else begin
               wrap_s = (cnt_r == LAST_C);
               if (wrap_s) begin
                  cnt_s = '0;
                  idx_s = idx_r + IDX_W'(1);
               end else begin
                  cnt_s = cnt_r + CW'(1);
                  idx_s = idx_r;
               end
               // Frame boundary: last digit's slot is ending.
               commit_s = pending_r && wrap_s && (idx_r == IDX_LAST);
               if (cnt_s < DEAD_C) begin
                  state_s = ST_BLANK;
               end else begin
                  state_s = ST_ON;
               end
            end
         end
         default: begin
            state_s = ST_OFF;
            cnt_s   = '0;
            idx_s   = '0;
         end
      endcase

      if (commit_s) begin
         disp_s = shadow_r;
      end else begin
         disp_s = disp_r;
      end
      valid_s = valid_r | commit_s;

      if (commit_s) begin
         pending_s = 1'b0;
      end else if (capture_s) begin
         pending_s = 1'b1;
      end else begin
         pending_s = pending_r;
      end

      if (capture_s) begin
         shadow_s = bus.data_in;
      end else begin
         shadow_s = shadow_r;
      end

      // Decode the nibble the next cycle will show, so outputs line up
      // with the registered state.
      case (idx_s)
         2'd0:    nib_s = disp_s[3:0];
         2'd1:    nib_s = disp_s[7:4];
         2'd2:    nib_s = disp_s[11:8];
         2'd3:    nib_s = disp_s[15:12];
         default: nib_s = 4'h0;
      endcase

      if (state_s == ST_ON) begin
         digit_sel_s = digit_onehot(idx_s);
      end else begin
         digit_sel_s = '0;
      end

      if (state_s == ST_OFF) begin
         segments_s = 7'b0000000;
      end else begin
         segments_s = dec_s;
      end
   end

   // State, data and registered output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_OFF;
         cnt_r       <= '0;
         idx_r       <= '0;
         shadow_r    <= 16'h0000;
         disp_r      <= 16'h0000;
         pending_r   <= 1'b0;
         valid_r     <= 1'b0;
         digit_sel_r <= '0;
         segments_r  <= 7'b0000000;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         idx_r       <= idx_s;
         shadow_r    <= shadow_s;
         disp_r      <= disp_s;
         pending_r   <= pending_s;
         valid_r     <= valid_s;
         digit_sel_r <= digit_sel_s;
         segments_r  <= segments_s;
      end
   end

   assign bus.ready     = ~pending_r;
   assign bus.digit_sel = digit_sel_r;
   assign bus.segments  = segments_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with CLK_DIV=8, DEAD_CYC=2.
module tb_seg7_scan_ctrl;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   seg7_scan_ctrl_if bus ();

   seg7_scan_ctrl #(.CLK_DIV(8), .DEAD_CYC(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board decoder table, copied from the display datasheet.
   function automatic logic [6:0] seg_ref(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b1010000;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1011110;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b0011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected display outputs at cycle k of a frame (8 cycles per digit,
   // first 2 blank).
   task automatic check_scan(input logic [15:0] val, input int k);
      int          d;
      int          c;
      logic [15:0] sh;
      logic [3:0]  exp_sel;
      d  = k / 8;
      c  = k % 8;
      sh = val >> (4 * d);
      case (d)
         0:       exp_sel = 4'b0001;
         1:       exp_sel = 4'b0010;
         2:       exp_sel = 4'b0100;
         default: exp_sel = 4'b1000;
      endcase
      if (c < 2) exp_sel = 4'b0000;
      chk($sformatf("dsel_%h_k%0d", val, k), {12'h000, bus.digit_sel}, {12'h000, exp_sel});
      chk($sformatf("seg_%h_k%0d", val, k), {9'h000, bus.segments}, {9'h000, seg_ref(sh[3:0])});
   endtask

   initial begin
      bus.en      = 1'b0;
      bus.load    = 1'b0;
      bus.data_in = 16'h0000;
      rst_n       = 1'b0;
      #12;
      chk("rst_dsel", {12'h000, bus.digit_sel}, 16'h0000);
      chk("rst_seg", {9'h000, bus.segments}, 16'h0000);
      chk("rst_ready", {15'h0000, bus.ready}, 16'h0001);
      @(negedge clk);
      rst_n  = 1'b1;
      bus.en = 1'b1;

      // Enabled but never loaded: stays dark.
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("idle_out", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      end
      chk("idle_ready", {15'h0000, bus.ready}, 16'h0001);

      // First load: capture, commit in OFF, then BLANK of digit 0.
      bus.data_in = 16'h3210;
      bus.load    = 1'b1;
      tick();
      bus.load    = 1'b0;
      chk("cap_ready", {15'h0000, bus.ready}, 16'h0000);
      tick();
      chk("commit_ready", {15'h0000, bus.ready}, 16'h0001);
      chk("commit_dark", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      tick();
      for (int k = 0; k < 32; k++) begin
         check_scan(16'h3210, k);
         tick();
      end

      // Mid-frame load at digit 1 with load held and data changing.
      for (int k = 0; k < 32; k++) begin
         check_scan(16'h3210, k);
         chk($sformatf("pend_ready_k%0d", k), {15'h0000, bus.ready}, (k <= 8) ? 16'h0001 : 16'h0000);
         bus.load    = (k >= 8) && (k < 31);
         bus.data_in = (k == 8) ? 16'h5555 : (16'h9000 + 16'(k));
         tick();
      end
      bus.load = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check_scan(16'h5555, k);
         chk("post_commit_ready", {15'h0000, bus.ready}, 16'h0001);
         tick();
      end

      // Drop en during ON of digit 2.
      for (int k = 0; k < 21; k++) begin
         check_scan(16'h5555, k);
         tick();
      end
      check_scan(16'h5555, 21);
      bus.en = 1'b0;
      tick();
      chk("en_off_out", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      tick();
      chk("en_off_out2", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      bus.en = 1'b1;
      tick();
      for (int k = 0; k < 32; k++) begin
         check_scan(16'h5555, k);
         tick();
      end

      // Pending load then asynchronous reset during ON of digit 1.
      for (int k = 0; k < 12; k++) begin
         check_scan(16'h5555, k);
         bus.load    = (k == 3);
         bus.data_in = 16'h8888;
         tick();
      end
      bus.load = 1'b0;
      check_scan(16'h5555, 12);
      chk("pre_rst_ready", {15'h0000, bus.ready}, 16'h0000);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      chk("async_rst_ready", {15'h0000, bus.ready}, 16'h0001);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post_rst_dark", {5'h00, bus.digit_sel, bus.segments}, 16'h0000);
      end

      // Fresh load restarts scanning.
      bus.data_in = 16'h8421;
      bus.load    = 1'b1;
      tick();
      bus.load    = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 32; k++) begin
         check_scan(16'h8421, k);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
